// File: rtl/dds_sweep_ctrl_if.sv
// Request/status bundle between a sweep requester (master) and dds_sweep_ctrl (slave).
interface dds_sweep_ctrl_if #(
    parameter int unsigned FTW_W   = 24,
    parameter int unsigned DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic               mode;
    logic [FTW_W-1:0]   f_start;
    logic [FTW_W-1:0]   f_stop;
    logic [FTW_W-1:0]   f_step;
    logic [DWELL_W-1:0] dwell;
    logic [FTW_W-1:0]   ftw_out;
    logic               ftw_valid;
    logic               dds_en;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, mode, f_start, f_stop, f_step, dwell,
        input  ftw_out, ftw_valid, dds_en, busy, done
    );

    modport slave (
        input  start, abort, mode, f_start, f_stop, f_step, dwell,
        output ftw_out, ftw_valid, dds_en, busy, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: steps the tuning word from f_start to f_stop,
// holding each point for a programmable dwell, single-shot or sawtooth.
module dds_sweep_ctrl #(
    parameter int unsigned FTW_W   = 24,
    parameter int unsigned DWELL_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    dds_sweep_ctrl_if.slave sweep
);
    typedef enum logic [2:0] {IDLE, LOAD, DWELL, STEP, FIN} state_t;

    state_t             state;
    logic [FTW_W-1:0]   s_start;
    logic [FTW_W-1:0]   s_stop;
    logic [FTW_W-1:0]   s_step;
    logic [DWELL_W-1:0] s_nm1;
    logic               s_mode;
    logic [DWELL_W-1:0] cnt;
    logic               last_q;
    logic [FTW_W-1:0]   ftw_q;
    logic               valid_q;
    logic               en_q;
    logic               busy_q;
    logic               done_q;

    logic [FTW_W:0]     sum_c;
    logic               step_last_c;
    logic               load_last_c;
    logic               single_c;
    state_t             expire_c;

    // Next point computed one bit wider so a carry out clamps to f_stop instead of wrapping.
    assign sum_c       = {1'b0, ftw_q} + {1'b0, s_step};
    assign step_last_c = sum_c[FTW_W] || (sum_c >= {1'b0, s_stop});
    assign load_last_c = (s_step == '0) || (s_start >= s_stop);
    assign single_c    = (s_nm1 == '0);
    assign expire_c    = s_mode ? LOAD : FIN;

    // LOAD/STEP/FIN each occupy the final cycle of the previous point so updates stay N apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            s_start <= '0;
            s_stop  <= '0;
            s_step  <= '0;
            s_nm1   <= '0;
            s_mode  <= 1'b0;
            cnt     <= '0;
            last_q  <= 1'b0;
            ftw_q   <= '0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (sweep.abort && (state != IDLE)) begin
                state  <= IDLE;
                en_q   <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // The done cycle is itself IDLE; a new request waits until it has passed.
                        if (sweep.start && !sweep.abort && !done_q) begin
                            s_start <= sweep.f_start;
                            s_stop  <= sweep.f_stop;
                            s_step  <= sweep.f_step;
                            s_mode  <= sweep.mode;
                            s_nm1   <= (sweep.dwell == '0) ? '0 : sweep.dwell - DWELL_W'(1);
                            state   <= LOAD;
                        end
                    end
                    LOAD: begin
                        ftw_q   <= s_start;
                        valid_q <= 1'b1;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= load_last_c;
                        cnt     <= s_nm1;
                        state   <= single_c ? (load_last_c ? expire_c : STEP) : DWELL;
                    end
                    DWELL: begin
                        if (cnt <= DWELL_W'(1)) begin
                            cnt   <= '0;
                            state <= last_q ? expire_c : STEP;
                        end else begin
                            cnt <= cnt - DWELL_W'(1);
                        end
                    end
                    STEP: begin
                        ftw_q   <= step_last_c ? s_stop : sum_c[FTW_W-1:0];
                        valid_q <= 1'b1;
                        last_q  <= step_last_c;
                        cnt     <= s_nm1;
                        state   <= single_c ? (step_last_c ? expire_c : STEP) : DWELL;
                    end
                    FIN: begin
                        done_q <= 1'b1;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign sweep.ftw_out   = ftw_q;
    assign sweep.ftw_valid = valid_q;
    assign sweep.dds_en    = en_q;
    assign sweep.busy      = busy_q;
    assign sweep.done      = done_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: point-list reference model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized sweeps.
module tb_dds_sweep_ctrl;
    localparam int unsigned FTW_W   = 24;
    localparam int unsigned DWELL_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dds_sweep_ctrl_if #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) sw();
    dds_sweep_ctrl #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .sweep (sw)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: phase 0 idle, 1 load pending, 2 running (m_r cycles since first point).
    int                phase  = 0;
    int                m_r    = 0;
    int                m_n    = 1;
    bit                m_mode = 1'b0;
    longint unsigned   pts[$];
    logic [FTW_W-1:0]  exp_ftw   = '0;
    logic              exp_valid = 1'b0;
    logic              exp_en    = 1'b0;
    logic              exp_busy  = 1'b0;
    logic              exp_done  = 1'b0;
    int                acc_cyc   = 0;

    longint unsigned   cap_ftw[$];
    int                cap_cyc[$];
    longint unsigned   exp_q[$];
    int                done_cyc  = -1;
    int                done_cnt  = 0;
    int                busy_cnt  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic build_points(input longint unsigned fs, input longint unsigned fe,
                                input longint unsigned fp);
        longint unsigned v;
        pts.delete();
        pts.push_back(fs);
        if (fp != 0 && fs < fe) begin
            v = fs;
            while (v < fe) begin
                v = v + fp;
                pts.push_back((v >= fe) ? fe : v);
            end
        end
    endtask

    task automatic model_edge();
        int k;
        int idx;
        if (!rst) begin
            phase   = 0;
            exp_ftw = '0;
        end else if (phase != 0 && sw.abort) begin
            phase = 0;
        end else begin
            case (phase)
                0: if (sw.start && !sw.abort) begin
                    build_points(longint'(sw.f_start), longint'(sw.f_stop), longint'(sw.f_step));
                    m_n     = (sw.dwell == '0) ? 1 : int'(sw.dwell);
                    m_mode  = sw.mode;
                    acc_cyc = cyc;
                    phase   = 1;
                end
                1: begin
                    phase = 2;
                    m_r   = 0;
                end
                default: begin
                    if (!m_mode && m_r == pts.size() * m_n) phase = 0;
                    else m_r = m_r + 1;
                end
            endcase
        end
        exp_valid = 1'b0;
        exp_en    = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        if (phase == 2) begin
            k = pts.size();
            if (!m_mode && m_r == k * m_n) begin
                exp_done = 1'b1;
            end else begin
                idx       = (m_r / m_n) % k;
                exp_ftw   = FTW_W'(pts[idx]);
                exp_valid = ((m_r % m_n) == 0);
                exp_busy  = 1'b1;
                exp_en    = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_edge();
        #1;
        check("ftw_out", sw.ftw_out, exp_ftw);
        check("ftw_valid", sw.ftw_valid, exp_valid);
        check("dds_en", sw.dds_en, exp_en);
        check("busy", sw.busy, exp_busy);
        check("done", sw.done, exp_done);
        if (sw.ftw_valid === 1'b1) begin
            cap_ftw.push_back(longint'(sw.ftw_out));
            cap_cyc.push_back(cyc);
        end
        if (sw.done === 1'b1) begin
            done_cyc = cyc;
            done_cnt = done_cnt + 1;
        end
        if (sw.busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_caps();
        cap_ftw.delete();
        cap_cyc.delete();
        done_cyc = -1;
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic set_cfg(input logic [FTW_W-1:0] fs, input logic [FTW_W-1:0] fe,
                           input logic [FTW_W-1:0] fp, input logic [DWELL_W-1:0] dw,
                           input logic md);
        sw.f_start = fs;
        sw.f_stop  = fe;
        sw.f_step  = fp;
        sw.dwell   = dw;
        sw.mode    = md;
    endtask

    // Inputs are scrambled after the request edge; the latched copy must be used.
    task automatic start_sweep(input logic [FTW_W-1:0] fs, input logic [FTW_W-1:0] fe,
                               input logic [FTW_W-1:0] fp, input logic [DWELL_W-1:0] dw,
                               input logic md);
        @(negedge clk);
        set_cfg(fs, fe, fp, dw, md);
        sw.start = 1'b1;
        @(negedge clk);
        sw.start   = 1'b0;
        sw.f_start = FTW_W'($urandom);
        sw.f_stop  = FTW_W'($urandom);
        sw.f_step  = FTW_W'($urandom);
        sw.dwell   = DWELL_W'($urandom);
        sw.mode    = 1'($urandom);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while (phase != 0 && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        check({nm, "_ends_in_budget"}, (phase != 0), 0);
    endtask

    task automatic do_abort();
        @(negedge clk);
        sw.abort = 1'b1;
        @(negedge clk);
        sw.abort = 1'b0;
    endtask

    task automatic check_caps(input string nm, input int spacing, input bit exact);
        if (exact) check({nm, "_count"}, cap_ftw.size(), exp_q.size());
        else       check({nm, "_enough"}, (cap_ftw.size() >= exp_q.size()), 1);
        for (int i = 0; i < exp_q.size() && i < cap_ftw.size(); i++) begin
            check({nm, "_ftw"}, cap_ftw[i], exp_q[i]);
            if (i > 0) check({nm, "_gap"}, cap_cyc[i] - cap_cyc[i-1], spacing);
        end
    endtask

    initial begin
        logic [FTW_W-1:0] frozen;
        sw.start = 1'b0;
        sw.abort = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_ftw", sw.ftw_out, 0);
        check("reset_valid", sw.ftw_valid, 0);
        check("reset_en", sw.dds_en, 0);
        check("reset_busy", sw.busy, 0);
        check("reset_done", sw.done, 0);
        rst = 1'b1;

        // Basic single sweep
        clear_caps();
        start_sweep(24'd100, 24'd130, 24'd10, 16'd3, 1'b0);
        wait_idle("basic", 200);
        exp_q = '{100, 110, 120, 130};
        check_caps("basic", 3, 1'b1);
        if (cap_cyc.size() == 4) begin
            check("basic_first_latency", cap_cyc[0] - acc_cyc, 1);
            check("basic_done_gap", done_cyc - cap_cyc[3], 3);
        end
        check("basic_busy_cycles", busy_cnt, 12);
        check("basic_done_count", done_cnt, 1);

        // Overshoot clamps to f_stop
        clear_caps();
        start_sweep(24'd100, 24'd125, 24'd10, 16'd2, 1'b0);
        wait_idle("overshoot", 200);
        exp_q = '{100, 110, 120, 125};
        check_caps("overshoot", 2, 1'b1);
        if (cap_cyc.size() == 4) check("overshoot_done_gap", done_cyc - cap_cyc[3], 2);
        check("overshoot_done_count", done_cnt, 1);

        // Carry out of the tuning word clamps, never wraps
        clear_caps();
        start_sweep(24'hFFFFF0, 24'hFFFFFF, 24'h20, 16'd1, 1'b0);
        wait_idle("overflow", 200);
        exp_q = '{64'hFFFFF0, 64'hFFFFFF};
        check_caps("overflow", 1, 1'b1);

        // Degenerate: one point, done next cycle; start raised during done is not taken
        clear_caps();
        start_sweep(24'd500, 24'd900, 24'd0, 16'd0, 1'b0);
        set_cfg(24'd500, 24'd900, 24'd0, 16'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sw.done === 1'b1) begin
                sw.start = 1'b1;
                @(negedge clk);
                sw.start = 1'b0;
                break;
            end
        end
        repeat (4) @(negedge clk);
        exp_q = '{500};
        check_caps("degenerate", 1, 1'b1);
        if (cap_cyc.size() == 1) check("degenerate_done_gap", done_cyc - cap_cyc[0], 1);
        check("degenerate_done_count", done_cnt, 1);

        // Continuous sawtooth, then abort
        clear_caps();
        start_sweep(24'd0, 24'd20, 24'd10, 16'd1, 1'b1);
        repeat (6) @(negedge clk);
        exp_q = '{0, 10, 20, 0, 10, 20};
        check_caps("continuous", 1, 1'b0);
        check("continuous_no_done", done_cnt, 0);
        frozen   = sw.ftw_out;
        sw.abort = 1'b1;
        @(negedge clk);
        sw.abort = 1'b0;
        check("abort_busy", sw.busy, 0);
        check("abort_en", sw.dds_en, 0);
        check("abort_ftw_frozen", sw.ftw_out, frozen);
        repeat (2) @(negedge clk);
        check("abort_ftw_still_frozen", sw.ftw_out, frozen);
        check("abort_no_done", done_cnt, 0);

        // start together with abort in IDLE does not start
        clear_caps();
        @(negedge clk);
        set_cfg(24'd5, 24'd50, 24'd5, 16'd1, 1'b0);
        sw.start = 1'b1;
        sw.abort = 1'b1;
        @(negedge clk);
        sw.start = 1'b0;
        sw.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("start_abort_no_pulse", cap_ftw.size(), 0);
        check("start_abort_busy", sw.busy, 0);

        // start while busy is ignored
        clear_caps();
        start_sweep(24'd100, 24'd130, 24'd10, 16'd3, 1'b0);
        repeat (4) @(negedge clk);
        set_cfg(24'd1000, 24'd2000, 24'd1, 16'd0, 1'b1);
        sw.start = 1'b1;
        @(negedge clk);
        sw.start = 1'b0;
        wait_idle("restart", 200);
        exp_q = '{100, 110, 120, 130};
        check_caps("restart_ignored", 3, 1'b1);
        check("restart_done_count", done_cnt, 1);

        // Asynchronous reset in mid-dwell
        clear_caps();
        start_sweep(24'd100, 24'd200, 24'd10, 16'd5, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ftw", sw.ftw_out, 0);
        check("async_rst_valid", sw.ftw_valid, 0);
        check("async_rst_en", sw.dds_en, 0);
        check("async_rst_busy", sw.busy, 0);
        check("async_rst_done", sw.done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("async_rst_no_done", done_cnt, 0);

        // Randomized sweeps
        for (int it = 0; it < 40; it++) begin
            logic [FTW_W-1:0]   fs;
            logic [FTW_W-1:0]   fe;
            logic [FTW_W-1:0]   fp;
            logic [DWELL_W-1:0] dw;
            logic               md;
            int                 sel;
            sel = $urandom_range(0, 9);
            dw  = DWELL_W'($urandom_range(0, 4));
            md  = ($urandom_range(0, 3) == 0);
            case (sel)
                0: begin
                    fs = FTW_W'($urandom_range(0, 32'hFFFF00));
                    fe = fs + FTW_W'($urandom_range(0, 100));
                    fp = '0;
                end
                1: begin
                    fs = FTW_W'($urandom_range(200, 32'hFFFF00));
                    fe = fs - FTW_W'($urandom_range(0, 150));
                    fp = FTW_W'($urandom_range(1, 20));
                end
                2: begin
                    fs = FTW_W'($urandom_range(32'hFFFF00, 32'hFFFFF0));
                    fe = FTW_W'($urandom_range(32'(fs), 32'hFFFFFF));
                    fp = FTW_W'($urandom_range(32'h10, 32'hFFFFFF));
                end
                default: begin
                    fs = FTW_W'($urandom_range(0, 32'hFFFF00));
                    fe = fs + FTW_W'($urandom_range(1, 150));
                    fp = FTW_W'($urandom_range(1, 40));
                end
            endcase
            clear_caps();
            start_sweep(fs, fe, fp, dw, md);
            if (md) begin
                repeat ($urandom_range(3, 60)) @(negedge clk);
                do_abort();
            end else if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 40)) @(negedge clk);
                do_abort();
            end else begin
                if ($urandom_range(0, 2) == 0) begin
                    @(negedge clk);
                    if (phase == 2 && m_r + 4 < pts.size() * m_n) begin
                        sw.start = 1'b1;
                        @(negedge clk);
                        sw.start = 1'b0;
                    end
                end
                wait_idle("rand", 3000);
                check("rand_points", cap_ftw.size(), pts.size());
                check("rand_done_count", done_cnt, 1);
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS phase-accumulator/sine-ROM datapath.
- Steps the frequency tuning word (FTW) from f_start to f_stop in increments of f_step.
- Holds each FTW for a programmable dwell count and gates the DDS with dds_en.
- Supports single-shot and continuous (sawtooth) sweeps, plus abort.

Parameters:
FTW_W, 24, width of tuning word and of f_start/f_stop/f_step
DWELL_W, 16, width of dwell counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low
start  input  1  sweep request, sampled only in IDLE
abort  input  1  stop sweep; highest priority
mode  input  1  0 = single sweep, 1 = continuous (reload f_start after f_stop)
f_start  input  FTW_W  first tuning word
f_stop  input  FTW_W  last tuning word (inclusive)
f_step  input  FTW_W  increment per point
dwell  input  DWELL_W  cycles per point (0 treated as 1)
ftw_out  output  FTW_W  tuning word to DDS, registered
ftw_valid  output  1  1-cycle pulse on every ftw_out load
dds_en  output  1  DDS accumulator enable, high while sweeping
busy  output  1  high from first load until DONE/abort
done  output  1  1-cycle pulse at end of single sweep

Behaviour:
- Reset (rst=0, async): state IDLE; ftw_out=0; ftw_valid=0; dds_en=0; busy=0; done=0; internal counters=0.
- States: IDLE, LOAD, DWELL, STEP, FIN. All outputs are registered.
- IDLE:
  - start=1 and abort=0 at edge E: latch f_start, f_stop, f_step, dwell, mode into shadow registers; go to LOAD.
  - Input changes after latching are ignored until the next IDLE.
- LOAD: ftw_out<=f_start; ftw_valid=1; dds_en=1; busy=1; dwell counter<=N-1, where N = dwell, or 1 if dwell=0.
  - First ftw_valid appears one cycle after start is sampled.
- DWELL: counter decrements each cycle. At 0: go to STEP if the current point is not the last; otherwise go to FIN.
  - Consecutive ftw_valid pulses are exactly N cycles apart.
- STEP:
  - Compute next = ftw_out + f_step in FTW_W+1 bits.
  - If next >= f_stop, or bit FTW_W (overflow) is set: ftw_out<=f_stop and mark the point as last.
  - Else: ftw_out<=next.
  - In both cases ftw_valid=1 and the counter reloads to N-1.
  - STEP replaces the last DWELL cycle, so update spacing stays N.
- Degenerate config: f_step=0 or f_start>=f_stop makes f_start the only point, and it is marked last at LOAD.
- Last point's dwell expires:
  - mode=0: go to FIN, which pulses done=1 for one cycle; dds_en=0 and busy=0 in that same cycle; next state IDLE.
  - mode=1: go directly to LOAD (f_start reloaded, spacing still N). done is never pulsed.
- ftw_out holds its last value after FIN or abort; it is changed only by LOAD/STEP or reset.
- abort=1 in any non-IDLE state: next edge forces IDLE with dds_en=0, busy=0, no ftw_valid, no done.
  - abort has priority over start, STEP and FIN.
  - abort in IDLE with start=1 means the sweep does not start.
- start while busy: ignored; no restart.
- Reset asserted mid-sweep: immediate return to reset values; no done pulse.
- After FIN, start is sampled again no earlier than the cycle following the done pulse.

Test Plan:
- f_start=100, f_stop=130, f_step=10, dwell=3, mode=0 -> ftw_out 100,110,120,130 with ftw_valid pulses 3 cycles apart; done 3 cycles after the 130 pulse; busy high for 12 cycles.
- Overshoot: start=100, stop=125, step=10, dwell=2 -> ftw 100,110,120,125 (clamped); exactly 4 ftw_valid pulses, then done.
- Overflow, FTW_W=24: start=0xFFFFF0, stop=0xFFFFFF, step=0x20 -> ftw 0xFFFFF0 then 0xFFFFFF; no wrap to a low value.
- Continuous: start=0, stop=20, step=10, dwell=1, mode=1 -> ftw 0,10,20,0,10,20... on every cycle with no done; abort mid-sequence -> next cycle busy=0, dds_en=0, ftw_out frozen.
- Degenerate: f_step=0, dwell=0, mode=0 -> single ftw_valid with f_start; done 1 cycle later.
- Reset/priority: rst low during DWELL -> all outputs 0 asynchronously. start and abort high together in IDLE -> remains IDLE. start pulsed while busy -> sequence unchanged.
